// File: rtl/iterator_table_mem_if.sv
// Request/response bundle between the iterator address generator and one
// per-namespace BASE/STRIDE table.
interface iterator_table_mem_if #(
    parameter int unsigned NS_INDEX_ID_BITS  = 5,
    parameter int unsigned BASE_STRIDE_WIDTH = 32
);
    logic                         read_req;
    logic [NS_INDEX_ID_BITS-1:0]  read_addr;
    logic                         write_req_base;
    logic [NS_INDEX_ID_BITS-1:0]  write_addr_base;
    logic [BASE_STRIDE_WIDTH-1:0] data_in_base;
    logic                         write_req_stride;
    logic [NS_INDEX_ID_BITS-1:0]  write_addr_stride;
    logic [BASE_STRIDE_WIDTH-1:0] data_in_stride;
    logic [BASE_STRIDE_WIDTH-1:0] iterator_base;
    logic [BASE_STRIDE_WIDTH-1:0] iterator_stride;
    logic                         rd_valid;
    logic                         init_busy;
    logic                         req_dropped;

    modport master (
        output read_req, read_addr,
        output write_req_base, write_addr_base, data_in_base,
        output write_req_stride, write_addr_stride, data_in_stride,
        input  iterator_base, iterator_stride, rd_valid, init_busy, req_dropped
    );

    modport slave (
        input  read_req, read_addr,
        input  write_req_base, write_addr_base, data_in_base,
        input  write_req_stride, write_addr_stride, data_in_stride,
        output iterator_base, iterator_stride, rd_valid, init_busy, req_dropped
    );
endinterface

// File: rtl/iterator_table_mem.sv
// Per-namespace BASE/STRIDE table: cleared entry by entry after reset, then
// serves 1-cycle reads with write-first forwarding per array.
module iterator_table_mem #(
    parameter int unsigned NS_INDEX_ID_BITS  = 5,
    parameter int unsigned BASE_STRIDE_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    iterator_table_mem_if.slave   mem_if
);
    localparam int unsigned DEPTH = 1 << NS_INDEX_ID_BITS;
    localparam logic [NS_INDEX_ID_BITS-1:0] LAST_IDX = NS_INDEX_ID_BITS'(DEPTH - 1);
    localparam logic [NS_INDEX_ID_BITS-1:0] ONE_IDX  = NS_INDEX_ID_BITS'(1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                        state_q;
    logic [NS_INDEX_ID_BITS-1:0]   clr_cnt_q;
    logic                          init_busy_q;
    logic                          rd_valid_q;
    logic                          req_dropped_q;
    logic [BASE_STRIDE_WIDTH-1:0]  base_q;
    logic [BASE_STRIDE_WIDTH-1:0]  stride_q;
    logic [BASE_STRIDE_WIDTH-1:0]  base_d;
    logic [BASE_STRIDE_WIDTH-1:0]  stride_d;
    logic                          any_req_s;

    logic [BASE_STRIDE_WIDTH-1:0]  base_mem   [DEPTH];
    logic [BASE_STRIDE_WIDTH-1:0]  stride_mem [DEPTH];

    // Read data with write-first forwarding, evaluated per array
    always_comb begin
        base_d    = base_mem[mem_if.read_addr];
        stride_d  = stride_mem[mem_if.read_addr];
        any_req_s = mem_if.read_req | mem_if.write_req_base | mem_if.write_req_stride;
        if (mem_if.write_req_base && (mem_if.write_addr_base == mem_if.read_addr)) begin
            base_d = mem_if.data_in_base;
        end else begin
            base_d = base_mem[mem_if.read_addr];
        end
        if (mem_if.write_req_stride && (mem_if.write_addr_stride == mem_if.read_addr)) begin
            stride_d = mem_if.data_in_stride;
        end else begin
            stride_d = stride_mem[mem_if.read_addr];
        end
    end

    // Array storage: zeroed by the clear pass, written by the generator once READY
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (state_q == ST_INIT) begin
                base_mem[clr_cnt_q]   <= '0;
                stride_mem[clr_cnt_q] <= '0;
            end else begin
                if (mem_if.write_req_base) begin
                    base_mem[mem_if.write_addr_base] <= mem_if.data_in_base;
                end
                if (mem_if.write_req_stride) begin
                    stride_mem[mem_if.write_addr_stride] <= mem_if.data_in_stride;
                end
            end
        end
    end

    // Control FSM with registered read data and status outputs
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q       <= ST_INIT;
            clr_cnt_q     <= '0;
            init_busy_q   <= 1'b1;
            base_q        <= '0;
            stride_q      <= '0;
            rd_valid_q    <= 1'b0;
            req_dropped_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    clr_cnt_q  <= clr_cnt_q + ONE_IDX;
                    rd_valid_q <= 1'b0;
                    if (any_req_s) begin
                        req_dropped_q <= 1'b1;
                    end
                    if (clr_cnt_q == LAST_IDX) begin
                        state_q     <= ST_READY;
                        init_busy_q <= 1'b0;
                    end
                end
                ST_READY: begin
                    rd_valid_q <= mem_if.read_req;
                    if (mem_if.read_req) begin
                        base_q   <= base_d;
                        stride_q <= stride_d;
                    end
                end
                default: begin
                    state_q     <= ST_INIT;
                    clr_cnt_q   <= '0;
                    init_busy_q <= 1'b1;
                    rd_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_if.iterator_base   = base_q;
    assign mem_if.iterator_stride = stride_q;
    assign mem_if.rd_valid        = rd_valid_q;
    assign mem_if.init_busy       = init_busy_q;
    assign mem_if.req_dropped     = req_dropped_q;

endmodule

// File: tb/tb_iterator_table_mem.sv
// Directed bench for iterator_table_mem: reads push expected data into a
// queue, a monitor pops and compares whenever rd_valid is seen.
module tb_iterator_table_mem;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [2*DW-1:0] exp_q [$];

    iterator_table_mem_if #(.NS_INDEX_ID_BITS(AW), .BASE_STRIDE_WIDTH(DW)) bus ();

    iterator_table_mem #(.NS_INDEX_ID_BITS(AW), .BASE_STRIDE_WIDTH(DW)) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .mem_if  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.read_req         = 1'b0;
        bus.write_req_base   = 1'b0;
        bus.write_req_stride = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] s);
        bus.write_req_base    = 1'b1;
        bus.write_addr_base   = a;
        bus.data_in_base      = b;
        bus.write_req_stride  = 1'b1;
        bus.write_addr_stride = a;
        bus.data_in_stride    = s;
        cyc();
        idle();
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] eb, input logic [DW-1:0] es);
        bus.read_req  = 1'b1;
        bus.read_addr = a;
        exp_q.push_back({eb, es});
        cyc();
        idle();
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            cyc();
            n++;
            if (!bus.init_busy) break;
        end
    endtask

    // Monitor: every rd_valid must match the oldest expected response
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_rd_valid: got rd_valid=1 expected no response");
                end else begin
                    logic [2*DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("rd_base", bus.iterator_base, e[2*DW-1:DW]);
                    chk("rd_stride", bus.iterator_stride, e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        int n;
        idle();
        bus.read_addr         = '0;
        bus.write_addr_base   = '0;
        bus.write_addr_stride = '0;
        bus.data_in_base      = '0;
        bus.data_in_stride    = '0;

        // Reset state and clear-pass length
        reset = 1'b0;
        cyc();
        cyc();
        chk("rst_base", bus.iterator_base, 32'h0);
        chk("rst_stride", bus.iterator_stride, 32'h0);
        chk("rst_rd_valid", {31'h0, bus.rd_valid}, 32'h0);
        chk("rst_init_busy", {31'h0, bus.init_busy}, 32'h1);
        chk("rst_req_dropped", {31'h0, bus.req_dropped}, 32'h0);
        reset = 1'b1;
        count_busy(n);
        chk("busy_edges", n, 32'd32);
        rd(5'd5, 32'h0, 32'h0);
        chk("first_read_valid", {31'h0, bus.rd_valid}, 32'h1);
        cyc();
        chk("rd_valid_pulse", {31'h0, bus.rd_valid}, 32'h0);

        // Same-cycle base+stride write, read next cycle
        wr(5'd3, 32'h0000_1234, 32'hFFFF_FFFC);
        rd(5'd3, 32'h0000_1234, 32'hFFFF_FFFC);
        cyc();
        chk("rd_valid_once", {31'h0, bus.rd_valid}, 32'h0);

        // Forwarding, per array, plus a non-matching address
        wr(5'd7, 32'h10, 32'h55);
        bus.write_req_base = 1'b1; bus.write_addr_base = 5'd7; bus.data_in_base = 32'h20;
        rd(5'd7, 32'h20, 32'h55);
        bus.write_req_stride = 1'b1; bus.write_addr_stride = 5'd7; bus.data_in_stride = 32'h66;
        rd(5'd7, 32'h20, 32'h66);
        bus.write_req_base = 1'b1; bus.write_addr_base = 5'd8; bus.data_in_base = 32'h99;
        rd(5'd7, 32'h20, 32'h66);
        rd(5'd8, 32'h99, 32'h0);

        // Requests during the clear pass are dropped and flagged
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 9; i++) cyc();
        chk("dropped_before", {31'h0, bus.req_dropped}, 32'h0);
        bus.write_req_base = 1'b1; bus.write_addr_base = 5'd0; bus.data_in_base = 32'hAA;
        cyc();
        idle();
        chk("dropped_edge10", {31'h0, bus.req_dropped}, 32'h1);
        bus.read_req = 1'b1; bus.read_addr = 5'd0;
        cyc();
        idle();
        chk("init_read_no_valid", {31'h0, bus.rd_valid}, 32'h0);
        count_busy(n);
        chk("busy_remaining", n, 32'd21);
        chk("dropped_sticky", {31'h0, bus.req_dropped}, 32'h1);
        rd(5'd0, 32'h0, 32'h0);
        chk("dropped_still", {31'h0, bus.req_dropped}, 32'h1);

        // Reset mid-clear re-clears the whole table
        wr(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 14; i++) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        count_busy(n);
        chk("busy_after_reclear", n, 32'd32);
        rd(5'd31, 32'h0, 32'h0);

        // Boundary addresses, back-to-back reads
        wr(5'd0, 32'hA0A0_0000, 32'h0000_0001);
        wr(5'd31, 32'h1357_9BDF, 32'h8000_0000);
        bus.read_req = 1'b1; bus.read_addr = 5'd0;
        exp_q.push_back({32'hA0A0_0000, 32'h0000_0001});
        cyc();
        chk("b2b_valid_1", {31'h0, bus.rd_valid}, 32'h1);
        bus.read_addr = 5'd31;
        exp_q.push_back({32'h1357_9BDF, 32'h8000_0000});
        cyc();
        idle();
        chk("b2b_valid_2", {31'h0, bus.rd_valid}, 32'h1);
        cyc();
        chk("b2b_valid_end", {31'h0, bus.rd_valid}, 32'h0);
        chk("hold_base", bus.iterator_base, 32'h1357_9BDF);

        cyc();
        cyc();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iterator_table_mem.md
# iterator_table_mem

Per-namespace iterator memory: stores BASE and STRIDE words for each namespace index, is written by the iterator address generator and answers its read requests. Six instances sit behind the generator, one per namespace ID 0–5. Each instance takes that namespace's read and write strobes and returns `iterator_base`/`iterator_stride`, which feed the generator's base+stride loop path. After reset, a sequential clear pass zeroes every entry before any request is accepted.

## Interface
- NS_INDEX_ID_BITS, 5, index address width
- BASE_STRIDE_WIDTH, 32, base/stride word width
- DEPTH, 1<<NS_INDEX_ID_BITS, entries per array
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- read_req  in  1  read strobe for this namespace
- read_addr  in  NS_INDEX_ID_BITS  read index
- write_req_base  in  1  BASE write strobe
- write_addr_base  in  NS_INDEX_ID_BITS  BASE write index
- data_in_base  in  BASE_STRIDE_WIDTH  BASE write data
- write_req_stride  in  1  STRIDE write strobe
- write_addr_stride  in  NS_INDEX_ID_BITS  STRIDE write index
- data_in_stride  in  BASE_STRIDE_WIDTH  STRIDE write data
- iterator_base  out  BASE_STRIDE_WIDTH  registered BASE read data
- iterator_stride  out  BASE_STRIDE_WIDTH  registered STRIDE read data
- rd_valid  out  1  one-cycle pulse, read data updated this cycle
- init_busy  out  1  clear pass in progress, requests ignored
- req_dropped  out  1  sticky: a request arrived while init_busy=1

## Operation
- Two independent arrays, base_mem[DEPTH] and stride_mem[DEPTH], both BASE_STRIDE_WIDTH wide. There is no reset on the array storage itself; it is cleared by the INIT pass.
- FSM has two states, INIT and READY, plus a clear counter `clr_cnt` of NS_INDEX_ID_BITS bits.
- INIT, on each edge with reset=1:
  - write 0 to base_mem[clr_cnt] and stride_mem[clr_cnt];
  - increment clr_cnt;
  - when clr_cnt==DEPTH-1, move to READY and set init_busy<=0.
- INIT, request handling:
  - all read_req, write_req_base and write_req_stride are ignored;
  - rd_valid stays 0;
  - any asserted strobe sets req_dropped<=1.
- READY, writes: write_req_base writes data_in_base to base_mem[write_addr_base]; write_req_stride writes data_in_stride to stride_mem[write_addr_stride]. Both may occur in the same cycle, at equal or different addresses.
- READY, reads: read_req latches base_mem[read_addr] and stride_mem[read_addr] into the outputs and sets rd_valid<=1. Without read_req, outputs hold their value and rd_valid<=0.
- Write-first forwarding: if read_req and a write hit the same address of the same array in the same cycle, the output takes the incoming write data, not the old entry. This is evaluated per array independently.
- Data is stored and returned verbatim. There is no sign handling and no arithmetic; base+stride is the generator's job.
- READY persists until reset.

## Timing
- Reset (reset=0 at an edge), from any state:
  - state<=INIT, clr_cnt<=0, init_busy<=1;
  - iterator_base<=0, iterator_stride<=0;
  - rd_valid<=0, req_dropped<=0.
- A reset asserted mid-clear or mid-operation restarts the clear pass from entry 0, and the array contents are fully re-cleared.
- Clear pass: reset released before edge 1, so edges 1..DEPTH clear entries 0..DEPTH-1.
  - init_busy reads 0 after edge DEPTH, i.e. 32 edges for defaults.
  - The first accepted request is the one sampled at edge DEPTH+1.
- Read latency is 1 cycle. read_req sampled at edge n gives data and rd_valid=1 after edge n.
- Read-after-write to a different cycle: a write at edge n is visible to a read sampled at edge n+1 or later.
- Back-to-back reads every cycle are supported, with rd_valid high continuously.
- The generator asserts read_req one cycle before its loop write-back. This block imposes no ordering beyond the forwarding rule.

## Test plan
- Reset then count:
  - stimulus: reset low 2 cycles, release, then read_req=1, addr=5 at edge 33;
  - expect: init_busy=1 for exactly 32 edges after release; after edge 33, iterator_base=0, iterator_stride=0, rd_valid=1.
- Write/read:
  - stimulus: base 0x0000_1234 and stride 0xFFFF_FFFC written at addr 3 in the same cycle; read addr 3 next cycle;
  - expect: base=0x0000_1234, stride=0xFFFF_FFFC, rd_valid pulses once.
- Forwarding:
  - stimulus: addr 7 holds base 0x10; in one cycle write base 0x20 at addr 7 and read addr 7; stride at addr 7 untouched;
  - expect: iterator_base=0x20, iterator_stride=old stride.
- Dropped request:
  - stimulus: write_req_base (addr 0, 0xAA) at edge 10 after reset release; read addr 0 once READY;
  - expect: req_dropped=1 from edge 10 onward; read returns 0.
- Reset mid-clear:
  - stimulus: fill addr 31 with 0xFFFF_FFFF in READY; assert reset; release; reassert reset at edge 15; release; wait 32 edges; read addr 31;
  - expect: 0, with init_busy high for the full 32 edges after the final release.
- Boundary and back-to-back:
  - stimulus: reads at addr 0 and addr 31 on consecutive cycles, with distinct data written to each beforehand;
  - expect: correct data on consecutive cycles, with rd_valid high 2 cycles.
